// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: arbitrates cmd_proc input between UART and the tour.
// Optional abort support is compiled in with `define TOUR_ABORT_EN.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic        tour_abort,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        clr_cmd_rdy_UART,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {IDLE, VERT, VACK, VDONE, HORZ, HACK, HDONE} state_t;

    localparam logic [4:0] LAST_IDX    = 5'(NUM_MOVES - 1);
    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_FANFARE  = 4'h3;
    localparam logic [7:0] HDG_N       = 8'h00;
    localparam logic [7:0] HDG_W       = 8'h3F;
    localparam logic [7:0] HDG_S       = 8'h7F;
    localparam logic [7:0] HDG_E       = 8'hBF;
    localparam logic [7:0] RESP_DONE   = 8'h5A;
    localparam logic [7:0] RESP_BUSY   = 8'hA5;

    state_t      state;
    logic        mem_wait;
    logic [7:0]  move_q;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic [7:0]  resp_q;

    // Lowest set bit selects the move; all-zero yields zero-length N0/E0 legs.
    function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input logic horz);
        logic [2:0] sel;
        logic [7:0] v_hdg, h_hdg;
        logic [3:0] v_sq, h_sq;
        sel = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (mv[i-1]) sel = 3'(i - 1);
        end
        case (sel)
            3'd0: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_N, 4'd2, HDG_E, 4'd1};
            3'd1: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_N, 4'd2, HDG_W, 4'd1};
            3'd2: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_N, 4'd1, HDG_W, 4'd2};
            3'd3: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_S, 4'd1, HDG_W, 4'd2};
            3'd4: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_S, 4'd2, HDG_W, 4'd1};
            3'd5: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_S, 4'd2, HDG_E, 4'd1};
            3'd6: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_S, 4'd1, HDG_E, 4'd2};
            3'd7: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_N, 4'd1, HDG_E, 4'd2};
            default: {v_hdg, v_sq, h_hdg, h_sq} = {HDG_N, 4'd0, HDG_E, 4'd0};
        endcase
        if (mv == '0) begin
            v_sq = '0;
            h_sq = '0;
        end
        return horz ? {OP_FANFARE, h_hdg, h_sq} : {OP_MOVE, v_hdg, v_sq};
    endfunction

`ifndef TOUR_ABORT_EN
    logic unused_abort;
    assign unused_abort = tour_abort;
`endif

    // Both leg-load states spend one wait cycle (mem_wait) so every leg starts 2 clocks after its trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mv_indx   <= '0;
            mem_wait  <= 1'b0;
            move_q    <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            resp_q    <= RESP_DONE;
        end else
`ifdef TOUR_ABORT_EN
        if (state != IDLE && tour_abort) begin
            state     <= IDLE;
            mv_indx   <= '0;
            cmd_rdy_q <= 1'b0;
            resp_q    <= RESP_DONE;
        end else
`endif
        begin
            case (state)
                IDLE: if (start_tour) begin
                    mv_indx  <= '0;
                    mem_wait <= 1'b1;
                    resp_q   <= RESP_BUSY;
                    state    <= VERT;
                end
                VERT: if (mem_wait) begin
                    mem_wait <= 1'b0;
                end else begin
                    move_q    <= move;
                    cmd_q     <= leg_cmd(move, 1'b0);
                    cmd_rdy_q <= 1'b1;
                    state     <= VACK;
                end
                VACK: if (clr_cmd_rdy) begin
                    cmd_rdy_q <= 1'b0;
                    state     <= VDONE;
                end
                VDONE: if (send_resp) begin
                    mem_wait <= 1'b1;
                    state    <= HORZ;
                end
                HORZ: if (mem_wait) begin
                    mem_wait <= 1'b0;
                end else begin
                    cmd_q     <= leg_cmd(move_q, 1'b1);
                    cmd_rdy_q <= 1'b1;
                    state     <= HACK;
                end
                HACK: if (clr_cmd_rdy) begin
                    cmd_rdy_q <= 1'b0;
                    resp_q    <= (mv_indx == LAST_IDX) ? RESP_DONE : RESP_BUSY;
                    state     <= HDONE;
                end
                HDONE: if (send_resp) begin
                    if (mv_indx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        mv_indx  <= mv_indx + 5'd1;
                        mem_wait <= 1'b1;
                        state    <= VERT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // UART path is combinational in IDLE, forced to reset values while rst is high.
    assign cmd              = (state == IDLE) ? (rst ? '0 : cmd_UART) : cmd_q;
    assign cmd_rdy          = (state == IDLE) ? (cmd_rdy_UART & ~rst) : cmd_rdy_q;
    assign clr_cmd_rdy_UART = (state == IDLE) & clr_cmd_rdy & ~rst;
    assign resp             = resp_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: passthrough table, tour runs against a knight-offset model.
module tb_tour_cmd_seq;

    localparam int N = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        tour_abort;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy_UART;
    logic [7:0]  resp;

    int errors = 0;
    int checks = 0;

    logic [7:0] tour_mem [32];

    // Knight offsets per move bit: rows north-positive, columns east-positive.
    int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};

    tour_cmd_seq #(.NUM_MOVES(N)) dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .tour_abort(tour_abort), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .resp(resp)
    );

    always #5 clk = ~clk;

    // Synchronous move memory: one clock of read latency.
    always @(posedge clk) move <= tour_mem[mv_indx];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_leg(input logic [7:0] mv, input bit horz);
        int d;
        int b;
        logic [7:0] hdg;
        b = -1;
        for (int i = 7; i >= 0; i--) if (mv[i]) b = i;
        d = (b < 0) ? 0 : (horz ? dx_t[b] : dy_t[b]);
        if (horz) hdg = (d < 0) ? 8'h3F : 8'hBF;
        else      hdg = (d < 0) ? 8'h7F : 8'h00;
        if (d < 0) d = -d;
        return {horz ? 4'h3 : 4'h2, hdg, 4'(d)};
    endfunction

    // Runs a tour; returns early once cmd_rdy is seen for leg number stop_leg (-1: never).
    task automatic run_tour(input int stop_leg, input bit rand_ack);
        int cyc;
        int d;
        logic [15:0] exp_c;
        start_tour = 1'b1;
        for (int k = 0; k < N; k++) begin
            for (int leg = 0; leg < 2; leg++) begin
                cyc = 0;
                do begin
                    @(negedge clk);
                    start_tour = 1'b0;
                    send_resp  = 1'b0;
                    cyc++;
                    if (cmd === cmd_UART) chk("uart_leak", {16'h0, cmd}, {16'h0, ~cmd_UART});
                end while (!cmd_rdy && cyc < 10);
                chk("leg_latency", cyc, 3);
                if (!cmd_rdy) return;
                exp_c = exp_leg(tour_mem[k], leg[0]);
                chk("mv_indx", {27'h0, mv_indx}, k);
                chk("leg_cmd", {16'h0, cmd}, {16'h0, exp_c});
                if (k * 2 + leg == stop_leg) return;
                d = rand_ack ? $urandom_range(0, 3) : 0;
                repeat (d) begin
                    @(negedge clk);
                    chk("cmd_hold", {15'h0, cmd_rdy, cmd}, {15'h0, 1'b1, exp_c});
                end
                clr_cmd_rdy = 1'b1;
                send_resp   = rand_ack && ($urandom_range(0, 3) == 0);
                #1;
                chk("uart_clr_blocked", {31'h0, clr_cmd_rdy_UART}, 0);
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                send_resp   = 1'b0;
                chk("rdy_fall", {31'h0, cmd_rdy}, 0);
                d = rand_ack ? $urandom_range(0, 3) : 0;
                repeat (d) @(negedge clk);
                send_resp = 1'b1;
                #1;
                chk("resp_at_send", {24'h0, resp}, (k == N - 1 && leg == 1) ? 32'h5A : 32'hA5);
            end
        end
        @(negedge clk);
        send_resp = 1'b0;
        chk("end_resp", {24'h0, resp}, 32'h5A);
        chk("end_passthru", {15'h0, cmd_rdy, cmd}, {15'h0, cmd_rdy_UART, cmd_UART});
    endtask

    typedef struct {
        logic [15:0] c_uart;
        logic        r_uart;
        logic        clr;
        logic [15:0] e_cmd;
        logic        e_rdy;
        logic        e_clr;
        logic [7:0]  e_resp;
    } pt_vec_t;

    initial begin
        pt_vec_t vecs [5];
        vecs[0] = '{16'h2002, 1'b1, 1'b0, 16'h2002, 1'b1, 1'b0, 8'h5A};
        vecs[1] = '{16'h2002, 1'b1, 1'b1, 16'h2002, 1'b1, 1'b1, 8'h5A};
        vecs[2] = '{16'hABCD, 1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1, 8'h5A};
        vecs[3] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h5A};
        vecs[4] = '{16'h3BF1, 1'b1, 1'b0, 16'h3BF1, 1'b1, 1'b0, 8'h5A};

        rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b1; send_resp = 1'b0; tour_abort = 1'b0;
        for (int i = 0; i < 32; i++) tour_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {cmd, cmd_rdy, clr_cmd_rdy_UART, resp, mv_indx},
            {16'h0000, 1'b0, 1'b0, 8'h5A, 5'd0});
        rst = 1'b0; clr_cmd_rdy = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            cmd_UART = vecs[i].c_uart; cmd_rdy_UART = vecs[i].r_uart; clr_cmd_rdy = vecs[i].clr;
            @(negedge clk);
            chk("passthru", {cmd, cmd_rdy, clr_cmd_rdy_UART, resp},
                {vecs[i].e_cmd, vecs[i].e_rdy, vecs[i].e_clr, vecs[i].e_resp});
        end
        clr_cmd_rdy = 1'b0;

        // Tours run with a UART command held pending that no tour command can equal.
        cmd_UART = 16'hFFFF; cmd_rdy_UART = 1'b1;

        for (int i = 0; i < N; i++) tour_mem[i] = 8'h01 << (i % 8);
        run_tour(-1, 1'b0);

        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0:       tour_mem[i] = 8'h00;
                1:       tour_mem[i] = 8'(1 << $urandom_range(0, 7));
                default: tour_mem[i] = 8'($urandom);
            endcase
        end
        run_tour(-1, 1'b1);

        // Mid-tour async reset in HACK of move 5, then a clean restart.
        run_tour(11, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("midtour_rst", {cmd, cmd_rdy, clr_cmd_rdy_UART, resp, mv_indx},
            {16'h0000, 1'b0, 1'b0, 8'h5A, 5'd0});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {15'h0, cmd_rdy, cmd}, {15'h0, 1'b1, 16'hFFFF});
        run_tour(-1, 1'b1);

`ifdef TOUR_ABORT_EN
        run_tour(0, 1'b0);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        tour_abort = 1'b1;
        @(negedge clk);
        tour_abort = 1'b0;
        chk("abort_idle", {cmd, cmd_rdy, resp, mv_indx}, {16'hFFFF, 1'b1, 8'h5A, 5'd0});
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_cmd", {cmd, resp}, {16'hFFFF, 8'h5A});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Sequences the solved knight's tour into drive commands for `cmd_proc`, and arbitrates `cmd_proc`'s command input between the UART wrapper and the tour. The block sits between `UART_wrapper`, the tour solver's move memory and `cmd_proc`.
- Before `start_tour`, UART commands pass straight through.
- After `start_tour`, each of the `NUM_MOVES` one-hot moves becomes two legs: vertical first, then horizontal.
- The block also selects the response byte returned to the host.

## Interface
Parameters:
- NUM_MOVES, 24: tour moves to issue; index width is 5 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_tour  in  1  one-cycle pulse from solver; begins the tour.
- move  in  8  one-hot move at `mv_indx`, valid the cycle after `mv_indx` changes.
- mv_indx  out  5  current move index.
- cmd_UART  in  16  command from the UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy  in  1  `cmd_proc` consumed the command.
- send_resp  in  1  `cmd_proc` finished a command.
- tour_abort  in  1  abort request (see Configuration).
- cmd  out  16  command to `cmd_proc`.
- cmd_rdy  out  1  command valid to `cmd_proc`.
- clr_cmd_rdy_UART  out  1  consume acknowledge to the UART wrapper.
- resp  out  8  response byte.

## Operation
- Command format:
  - `[15:12]` opcode: 4'h2 MOVE, 4'h3 MOVE_FANFARE.
  - `[11:4]` heading: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
  - `[3:0]` squares.
- Move decode (bit: vertical leg, horizontal leg):
  - bit0: N2, E1
  - bit1: N2, W1
  - bit2: N1, W2
  - bit3: S1, W2
  - bit4: S2, W1
  - bit5: S2, E1
  - bit6: S1, E2
  - bit7: N1, E2
- Zero-hot or multi-hot `move`: the lowest set bit wins; all-zero issues N0 / E0 (legal, zero-length).
- The vertical leg uses MOVE; the horizontal leg uses MOVE_FANFARE.
- FSM states:
  - IDLE: mux selects UART; `cmd = cmd_UART`, `cmd_rdy = cmd_rdy_UART`, `clr_cmd_rdy_UART = clr_cmd_rdy`. On `start_tour`, clear `mv_indx` and go to VERT.
  - VERT: load the vertical command and assert `cmd_rdy`; go to VACK.
  - VACK: on `clr_cmd_rdy`, drop `cmd_rdy` and go to VDONE.
  - VDONE: on `send_resp`, go to HORZ.
  - HORZ: load the horizontal command and assert `cmd_rdy`; go to HACK.
  - HACK: on `clr_cmd_rdy`, drop `cmd_rdy` and go to HDONE.
  - HDONE: on `send_resp`, if `mv_indx == NUM_MOVES-1` go to IDLE; else increment `mv_indx` and go to VERT.
- In every state other than IDLE, UART is blocked: `clr_cmd_rdy_UART = 0`, and `cmd_rdy_UART` is ignored and remains pending at the wrapper.
- `resp`:
  - 8'h5A in IDLE and in HDONE of the last move.
  - 8'hA5 in all other tour states.
  - `resp` must be stable in the cycle `send_resp` is high.
- `start_tour` outside IDLE is ignored.
- `clr_cmd_rdy` and `send_resp` in the same cycle in a xACK state: treat as ack only; `send_resp` is expected later.

## Timing
- Reset values:
  - state IDLE
  - `mv_indx` 0
  - `cmd` 16'h0000
  - `cmd_rdy` 0
  - `clr_cmd_rdy_UART` 0
  - `resp` 8'h5A
- `cmd` and `cmd_rdy` are registered in tour mode. They are combinational pass-through in IDLE (zero latency).
- `start_tour` to first `cmd_rdy` high: 2 clocks. `cmd` is valid in the same cycle as `cmd_rdy` and is held until `clr_cmd_rdy`.
- `cmd_rdy` falls in the cycle after `clr_cmd_rdy`.
- `send_resp` to next-leg `cmd_rdy`: 2 clocks.
- `mv_indx` is updated in HDONE. VERT waits one cycle for memory latency before latching `move`.
- Async `rst` mid-tour returns to IDLE immediately. No partial command is replayed.

## Configuration
- `TOUR_ABORT_EN` defined: `tour_abort` high in any non-IDLE state forces IDLE on the next clock.
  - `cmd_rdy` drops, `mv_indx` clears, and `resp` becomes 8'h5A.
  - An in-flight `send_resp` after abort is ignored.
- Not defined: `tour_abort` is unused; the tour always runs to completion.

## Test plan
- UART passthrough: IDLE, `cmd_UART` = 16'h2002, `cmd_rdy_UART` = 1 -> same-cycle `cmd` = 16'h2002 and `cmd_rdy` = 1; `clr_cmd_rdy` mirrored to `clr_cmd_rdy_UART`; `resp` = 8'h5A.
- Single decode: `start_tour`, `move[0]` = 8'h01 -> `cmd` 16'h2002 (N2); after ack and `send_resp`, `cmd` 16'h3BF1 (E1); `resp` = 8'hA5 at both `send_resp`s.
- Full tour: 24 moves cycling through bits 0-7 -> 48 commands with correct headings; `mv_indx` goes 0 to 23; final `resp` 8'h5A; return to IDLE.
- UART blocking: `cmd_rdy_UART` held high mid-tour -> `clr_cmd_rdy_UART` stays 0 and `cmd` never equals `cmd_UART` until IDLE.
- Reset mid-tour: assert `rst` in HACK of move 5 -> all outputs at reset values in the same cycle; a new `start_tour` restarts at `mv_indx` 0.
- Abort (`TOUR_ABORT_EN`): `tour_abort` in VDONE -> IDLE next clock, `resp` 8'h5A, a subsequent `send_resp` causes no command.
